// File: rtl/sum_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3) with start/busy/done handshake.
// Optional active-low 7-segment decode with leading-zero blanking when SUM_BCD_SEG7_EN is defined.
module sum_bcd_converter #(
    parameter int unsigned IN_W   = 9,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [IN_W-1:0]       sum_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
`ifdef SUM_BCD_SEG7_EN
    ,
    output logic [7*DIGITS-1:0]   hex_out
`endif
);

    localparam int unsigned CntW = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int unsigned BcdW = 4 * DIGITS;

    typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

    state_e              state_q;
    logic [IN_W-1:0]     shift_q;
    logic [BcdW-1:0]     scratch_q;
    logic [CntW-1:0]     cnt_q;

    logic [BcdW-1:0]      adj;
    logic [BcdW+IN_W-1:0] shifted;

    // Add-3 correction on every digit >= 5, then one left shift of {scratch, shift}.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        shifted = {adj, shift_q} << 1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bcd_out   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        shift_q   <= sum_in;
                        scratch_q <= '0;
                        cnt_q     <= CntW'(IN_W - 1);
                        busy      <= 1'b1;
                        state_q   <= StConv;
                    end
                end
                StConv: begin
                    {scratch_q, shift_q} <= shifted;
                    cnt_q                <= cnt_q - CntW'(1);
                    if (cnt_q == '0) begin
                        bcd_out <= shifted[BcdW+IN_W-1 -: BcdW];
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef SUM_BCD_SEG7_EN
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // Walk from the most significant digit; blank zeros until the first non-zero or the ones digit.
    always_comb begin
        logic lead;
        lead    = 1'b1;
        hex_out = '1;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            if (lead && (bcd_out[4*i +: 4] == 4'd0) && (i != 0)) begin
                hex_out[7*i +: 7] = 7'b1111111;
            end else begin
                hex_out[7*i +: 7] = seg7(bcd_out[4*i +: 4]);
                lead              = 1'b0;
            end
        end
    end
`endif

endmodule
